// File: rtl/bg_noise_pkg.sv
// rtl/bg_noise_pkg.sv - shared constants, FSM state encoding and DW-bit saturation helper
package bg_noise_pkg;

    localparam int LANES     = 16;
    localparam int DW        = 8;
    localparam int AW        = 16;
    localparam int LOG2_NPER = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALIB = 2'd1,
        AVG   = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Clamp a DW+1 bit signed difference into DW bits. Overflow shows up as
    // disagreement between the two top bits; the sign bit picks the rail.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v[DW] != v[DW-1]) begin
            r = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_noise_remove_if.sv
// rtl/bg_noise_remove_if.sv - period-beat input stream and residual output stream
// master: upstream/downstream side (drives in_valid, in_data, out_ready)
// slave : bg_noise_remove (drives in_ready, out_valid, out_data)
interface bg_noise_remove_if;

    logic                                                in_valid;
    logic                                                in_ready;
    logic [bg_noise_pkg::LANES*bg_noise_pkg::DW-1:0]     in_data;
    logic                                                out_valid;
    logic                                                out_ready;
    logic [bg_noise_pkg::LANES*bg_noise_pkg::DW-1:0]     out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/bg_noise_lane.sv
// rtl/bg_noise_lane.sv - one lane: noise accumulator, average register, subtract/saturate
// Ports: clk, rst_n; clr (zero accumulator), acc_en (add sample), avg_en (latch
// floor average), run_en (register saturated residual); sample in; avg, res out.
module bg_noise_lane
    import bg_noise_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic                 avg_en,
    input  logic                 run_en,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] avg,
    output logic signed [DW-1:0] res
);

    logic signed [AW-1:0] acc;
    logic signed [DW:0]   diff;

    assign diff = {sample[DW-1], sample} - {avg[DW-1], avg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + {{(AW-DW){sample[DW-1]}}, sample};
        end
    end

    // Selecting bits above LOG2_NPER is the arithmetic shift (floor toward
    // -inf); the upper bits are pure sign extension because the sum of
    // 2^LOG2_NPER DW-bit values always fits in DW+LOG2_NPER bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg <= '0;
        end else if (avg_en) begin
            avg <= acc[LOG2_NPER +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (run_en) begin
            res <= sat_dw(diff);
        end
    end

endmodule

// File: rtl/bg_noise_remove.sv
// rtl/bg_noise_remove.sv - background-noise calibration and per-lane subtraction
// Ports: clk, rst_n (async active-low); start pulse begins/restarts calibration;
// bus (slave) carries the input period beats and output residual stream;
// noise_avg is the per-lane floor average; calib_done is high in RUN.
module bg_noise_remove
    import bg_noise_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    bg_noise_remove_if.slave    bus,
    output logic [LANES*DW-1:0] noise_avg,
    output logic                calib_done
);

    state_t               state_q;
    state_t               state_d;
    logic [LOG2_NPER-1:0] cnt;
    logic                 out_valid_q;
    logic                 in_ready_c;
    logic                 in_fire;
    logic                 clr;
    logic                 acc_en;
    logic                 avg_en;
    logic                 run_en;
    logic [LANES*DW-1:0]  res_bus;

    always_comb begin
        in_ready_c = 1'b0;
        unique case (state_q)
            CALIB:   in_ready_c = 1'b1;
            RUN:     in_ready_c = !out_valid_q || bus.out_ready;
            default: in_ready_c = 1'b0;
        endcase
    end

    assign in_fire = bus.in_valid && in_ready_c;

    // start is ignored only in AVG; a beat accepted in the same cycle as start
    // is dropped so the new calibration or pending flush starts clean.
    assign clr    = start && (state_q != AVG);
    assign acc_en = (state_q == CALIB) && in_fire && !start;
    assign avg_en = (state_q == AVG);
    assign run_en = (state_q == RUN) && in_fire && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CALIB;
            end
            CALIB: begin
                if (start) begin
                    state_d = CALIB;
                end else if (in_fire && (cnt == {LOG2_NPER{1'b1}})) begin
                    state_d = AVG;
                end
            end
            AVG: begin
                state_d = RUN;
            end
            RUN: begin
                if (start) state_d = CALIB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (acc_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
        end else if (run_en) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bg_noise_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .acc_en (acc_en),
            .avg_en (avg_en),
            .run_en (run_en),
            .sample (bus.in_data[DW*i +: DW]),
            .avg    (noise_avg[DW*i +: DW]),
            .res    (res_bus[DW*i +: DW])
        );
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_bus;
    assign calib_done    = (state_q == RUN);

endmodule

// File: doc/bg_noise_remove.md
Name: bg_noise_remove

Overview:
- Consumer of per-period background-noise sums, and the partner block to the noise-sum accumulator.
- Calibration phase: sums 2^LOG2_NPER period beats of 16 signed 8-bit lanes into signed 16-bit per-lane accumulators, then derives the per-lane average noise floor.
- Run phase: subtracts that average from every following period beat and emits saturated signed 8-bit residuals to the detection stage over a valid/ready stream.

Parameters:
- LANES, 16, samples per period beat
- DW, 8, signed sample width
- AW, 16, signed accumulator width; must satisfy DW+LOG2_NPER <= AW
- LOG2_NPER, 4, log2 of the number of calibration beats (16)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins or restarts calibration
- in_valid  in  1  period beat valid
- in_ready  out  1  period beat accepted when in_valid&&in_ready
- in_data  in  LANES*DW  lane i = in_data[DW*i +: DW], signed
- out_valid  out  1  residual beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DW  lane i = sat(in_lane_i - avg_i), signed
- noise_avg  out  LANES*DW  current per-lane average, signed
- calib_done  out  1  high while an average is valid (RUN state)

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - state=IDLE
  - in_ready=0, out_valid=0, out_data=0
  - noise_avg=0, calib_done=0
  - accumulators=0, beat counter=0
- States:
  - IDLE: in_ready=0. start -> CALIB.
  - CALIB: in_ready=1. Each accepted beat does acc_i += sign_extend(lane_i), and cnt increments. When the beat with cnt==2^LOG2_NPER-1 is accepted -> AVG.
  - AVG: exactly one cycle, in_ready=0. avg_i = acc_i >>> LOG2_NPER (arithmetic shift, floor toward -inf), truncated to DW; the result always fits. Register into noise_avg. -> RUN.
  - RUN: calib_done=1. Single output register stage; in_ready = !out_valid || out_ready.
- Run datapath:
  - On an accepted beat, out_data lane = sat_DW(sign_extend(lane) - avg_i), computed at DW+1 bits.
  - Saturation limits are -128..127.
  - out_valid is set on the next clock. Latency is 1 cycle.
- Output handshake:
  - out_valid clears on out_ready with no new input.
  - Simultaneous accept-in and drain-out keeps out_valid=1 with new data. Full throughput of 1 beat per cycle.
  - out_data is stable while out_valid && !out_ready.
- Entering CALIB (from any state):
  - acc and cnt clear on the same edge.
  - calib_done=0.
  - out_valid=0 (any pending residual is discarded).
  - noise_avg keeps its old value until AVG.
- start in CALIB restarts the count; the beat accepted in that same cycle is discarded.
- start during AVG is ignored.
- in_valid in IDLE/AVG: not accepted (in_ready=0); the upstream beat is held.
- Reset mid-CALIB or mid-RUN returns to the reset values immediately; no partial average is kept.
- Lanes are fully independent; there is no cross-lane arithmetic.

Decomposition:
- Shared package (bg_noise_pkg):
  - LANES, DW, AW, LOG2_NPER defaults
  - state enum {IDLE, CALIB, AVG, RUN}
  - function sat_dw(signed [DW:0]) -> signed [DW-1:0]
- One natural sub-module: bg_noise_lane.
  - Holds one lane's accumulator, average register and subtract/saturate logic.
  - Inputs: clr, acc_en, avg_en, run_en.
  - The top module generates LANES instances and owns the FSM, counter and handshake.

Test Plan:
1. Reset, start, 16 beats with all lanes=3 -> noise_avg lanes=3, calib_done rises 2 cycles after the 16th accept; then input lanes=10 -> out_data lanes=7 one cycle later.
2. Floor rounding: lane0 gets -3 x15 and -2 x1 (sum -47) -> avg0=-3. Lane1 gets 1 x15 and 2 x1 (sum 17) -> avg1=1.
3. Saturation: calibrate lane to 100, input -128 -> -128. Calibrate to -100, input 100 -> 127. Calibrate to -1, input 127 -> 127.
4. Backpressure: stream 8 beats in RUN with out_ready toggling 1,0,0,1 -> no beat lost or duplicated, out_data stable while stalled, in_ready low whenever out_valid && !out_ready.
5. Restart/reset: start mid-RUN with out_valid=1 -> out_valid=0, calib_done=0, old noise_avg held until the new AVG. Assert rst_n low after 7 CALIB beats -> all outputs zero asynchronously, state IDLE, next start needs a full 16 beats.
6. Lane independence: lane i calibrated to i-8 with input 0 -> out lane i = 8-i for all 16 lanes.
